morse_letter_ctrl: RTL and testbench
====================================

Name: morse_letter_ctrl

Overview:
Controller sitting directly downstream of the morse symbol decoder. It collects the decoder's one-cycle dot/line pulses into a per-letter code word and closes the letter after an idle gap. It then presents the letter to the character-mapping stage over a valid/ready handshake and pulses a decoder resync (active-low) once each letter is accepted.

Parameters:
MAX_SYMBOLS, 5, maximum symbols stored per letter.
LETTER_GAP, 6, consecutive idle sample ticks after the last symbol that close a letter; legal range 1..255.
LEN_W, 3, width of letter_len; must satisfy 2^LEN_W > MAX_SYMBOLS.

Ports:
clock  in  1  system clock; sole clock of the block.
reset  in  1  asynchronous, active-high reset.
tick  in  1  sample-enable strobe, same rate at which the decoder advances.
key_idle  in  1  raw key level, 1 = not pressed.
ld_dot  in  1  dot detected (1-cycle pulse from decoder).
ld_line  in  1  line detected (1-cycle pulse from decoder).
letter_ready  in  1  downstream accepts letter.
letter_valid  out  1  letter word valid.
letter_code  out  MAX_SYMBOLS  bit i = symbol i (0 dot, 1 line); symbol 0 is first keyed; unused bits 0.
letter_len  out  LEN_W  number of stored symbols, 1..MAX_SYMBOLS.
letter_ovf  out  1  more than MAX_SYMBOLS symbols were keyed for this letter.
sym_err  out  1  1-cycle pulse: ld_dot and ld_line high together.
sym_drop  out  1  1-cycle pulse: a symbol arrived while in S_EMIT and was discarded.
dec_resetn  out  1  decoder resync, active-low.

Behaviour:
- Reset (async, active-high): state S_IDLE; code, len, ovf, gap counter = 0; letter_valid = 0; sym_err = 0; sym_drop = 0; dec_resetn = 0 while reset is high and 1 after reset deasserts.
- Symbol event: exactly one of ld_dot or ld_line is high in the cycle.
- Error event: ld_dot and ld_line both high. It pulses sym_err the next cycle, is otherwise ignored, and does not clear the gap counter.
- Gap counter:
  - Clears on any symbol event or whenever key_idle = 0.
  - Otherwise increments on tick and saturates at LETTER_GAP.
- S_IDLE:
  - letter_valid = 0.
  - Symbol event: store it at bit 0, len = 1, clear gap, go to S_COLLECT.
  - Idle ticks do nothing.
- S_COLLECT:
  - Symbol event with len < MAX_SYMBOLS: store it at bit[len], then len+1.
  - Symbol event with len = MAX_SYMBOLS: code and len unchanged, ovf set (sticky for the letter).
  - Gap reaching LETTER_GAP (the increment that makes it equal): go to S_EMIT next cycle.
  - If a symbol event and the closing tick coincide, the symbol wins: it is stored and the gap clears.
- S_EMIT:
  - letter_valid = 1.
  - code, len and ovf are held stable until the handshake completes.
  - Symbol events here are discarded and pulse sym_drop the next cycle.
  - letter_valid & letter_ready: clear code, len and ovf; dec_resetn low for exactly the next cycle; go to S_IDLE.
  - letter_valid may be high in consecutive cycles only for the same letter. letter_ready is don't-care outside S_EMIT.
- Latency: letter_valid rises 1 cycle after the closing tick. Minimum letter turnaround is 2 cycles after acceptance.
- All outputs are registered.
- Reset mid-letter or mid-EMIT: the letter is lost and no valid is produced.

Decomposition:
- Package morse_pkg holds:
  - state encoding localparams S_IDLE = 2'd0, S_COLLECT = 2'd1, S_EMIT = 2'd2;
  - the symbol encodings SYM_DOT = 1'b0, SYM_LINE = 1'b1;
  - the default MAX_SYMBOLS and LETTER_GAP.
- One natural sub-module, morse_gap_timer: the saturating gap counter with clear/tick inputs and a done output. Everything else stays in morse_letter_ctrl.

Test Plan:
1. Key "A" (dot, line), then 6 idle ticks, ready held high -> valid for 1 cycle with code = 5'b00010, len = 2, ovf = 0, then dec_resetn low for 1 cycle.
2. Key 7 dots, then gap -> code = 5'b00000, len = 5, ovf = 1.
3. Letter "T" (line) with ready held low for 10 cycles, then a dot pulse during the wait, then ready high -> code = 5'b00001, len = 1 stable throughout; sym_drop pulses once; letter accepted on the ready cycle.
4. Dot, then 5 idle ticks, then line coincident with the 6th tick, then 6 idle ticks -> single letter with code = 5'b00010, len = 2.
5. ld_dot and ld_line high together in S_IDLE -> sym_err pulse; state stays S_IDLE; no valid.
6. Reset asserted during S_COLLECT with len = 3 -> immediately len = 0 and letter_valid = 0, and no letter is emitted after reset is released.

Source files
------------

// File: rtl/morse_letter_ctrl_pkg.sv
// Shared constants for the morse letter controller: FSM state encoding,
// symbol bit encoding and default letter geometry.
package morse_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_LINE = 1'b1;

  localparam int MAX_SYMBOLS_DEF = 5;
  localparam int LETTER_GAP_DEF  = 6;
  localparam int LEN_W_DEF       = 3;

  // Bit value stored for a single-symbol event (only ld_line matters once
  // the pair is known to be exclusive).
  function automatic logic sym_bit(input logic is_line);
    return is_line ? SYM_LINE : SYM_DOT;
  endfunction

endpackage

// File: rtl/morse_letter_ctrl_if.sv
// Letter hand-off bus between the letter controller and the
// character-mapping stage (valid/ready with code, length and overflow).
interface morse_letter_ctrl_if
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = MAX_SYMBOLS_DEF,
  parameter int LEN_W       = LEN_W_DEF
);
  logic                   letter_valid;
  logic                   letter_ready;
  logic [MAX_SYMBOLS-1:0] letter_code;
  logic [LEN_W-1:0]       letter_len;
  logic                   letter_ovf;

  modport master (
    output letter_valid, letter_code, letter_len, letter_ovf,
    input  letter_ready
  );

  modport slave (
    input  letter_valid, letter_code, letter_len, letter_ovf,
    output letter_ready
  );
endinterface

// File: rtl/morse_letter_ctrl_gap_timer.sv
// Saturating idle-gap counter. done is high in the cycle whose tick brings
// the count up to LETTER_GAP, so the letter can close on the next edge.
module morse_gap_timer #(
  parameter int LETTER_GAP = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic done
);
  localparam logic [7:0] GAP_MAX = 8'(LETTER_GAP);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear dominates, otherwise count ticks up to saturation.
  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && (cnt_q < GAP_MAX)) begin
      cnt_d = cnt_q + 8'd1;
      done  = (cnt_d == GAP_MAX);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/morse_letter_ctrl.sv
// Collects decoder dot/line pulses into a letter, closes it after an idle
// gap, offers it downstream over valid/ready and resyncs the decoder after
// each accepted letter.
module morse_letter_ctrl
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = MAX_SYMBOLS_DEF,
  parameter int LETTER_GAP  = LETTER_GAP_DEF,
  parameter int LEN_W       = LEN_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                key_idle,
  input  logic                ld_dot,
  input  logic                ld_line,
  morse_letter_ctrl_if.master lbus,
  output logic                sym_err,
  output logic                sym_drop,
  output logic                dec_resetn
);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_SYMBOLS);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]             state_q, state_d;
  logic [MAX_SYMBOLS-1:0] code_q, code_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic                   err_q, drop_q, rstn_q;

  logic sym_ev, err_ev, accept, gap_clr, gap_done;

  assign sym_ev  = ld_dot ^ ld_line;
  assign err_ev  = ld_dot & ld_line;
  assign accept  = valid_q & lbus.letter_ready;
  // A simultaneous dot+line is not a symbol, so it leaves the gap running.
  assign gap_clr = sym_ev | ~key_idle;

  morse_gap_timer #(.LETTER_GAP(LETTER_GAP)) u_gap (
    .clock (clock),
    .reset (reset),
    .clr   (gap_clr),
    .tick  (tick),
    .done  (gap_done)
  );

  // Letter FSM and code/length/overflow datapath.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (sym_ev) begin
          code_d    = '0;
          code_d[0] = sym_bit(ld_line);
          len_d     = LEN_ONE;
          ovf_d     = 1'b0;
          state_d   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A symbol on the closing tick also clears the gap, so it wins.
        if (sym_ev) begin
          if (len_q < LEN_MAX) begin
            code_d[len_q] = sym_bit(ld_line);
            len_d         = len_q + LEN_ONE;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (gap_done) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (accept) begin
          code_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_EMIT);
  end

  // Letter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Status pulses and decoder resync; resync is held low during reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      rstn_q <= 1'b0;
    end else begin
      err_q  <= err_ev;
      drop_q <= sym_ev && (state_q == S_EMIT);
      rstn_q <= ~accept;
    end
  end

  assign lbus.letter_valid = valid_q;
  assign lbus.letter_code  = code_q;
  assign lbus.letter_len   = len_q;
  assign lbus.letter_ovf   = ovf_q;
  assign sym_err           = err_q;
  assign sym_drop          = drop_q;
  assign dec_resetn        = rstn_q;
endmodule

// File: tb/tb_morse_letter_ctrl.sv
// Scoreboard bench for morse_letter_ctrl: a symbol-list reference model
// predicts accepted letters and per-cycle status; a monitor compares.
module tb_morse_letter_ctrl;
  localparam int MAXS = 5;
  localparam int GAP  = 6;
  localparam int LW   = 3;

  typedef struct {
    logic [MAXS-1:0] code;
    logic [LW-1:0]   len;
    logic            ovf;
  } letter_t;

  typedef struct {
    logic valid;
    logic err;
    logic drop;
    logic rstn;
  } flag_t;

  typedef struct {
    int              kind;   // 0 last letter, 1 reset state, 3 leftovers
    int              tnum;
    logic [MAXS-1:0] code;
    logic [LW-1:0]   len;
    logic            ovf;
    int              nlet;
  } dir_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, key_idle = 1'b1, ld_dot = 1'b0, ld_line = 1'b0;
  logic sym_err, sym_drop, dec_resetn;

  morse_letter_ctrl_if #(.MAX_SYMBOLS(MAXS), .LEN_W(LW)) lif ();

  morse_letter_ctrl #(.MAX_SYMBOLS(MAXS), .LETTER_GAP(GAP), .LEN_W(LW)) dut (
    .clock      (clk),
    .reset      (rst),
    .tick       (tick),
    .key_idle   (key_idle),
    .ld_dot     (ld_dot),
    .ld_line    (ld_line),
    .lbus       (lif),
    .sym_err    (sym_err),
    .sym_drop   (sym_drop),
    .dec_resetn (dec_resetn)
  );

  always #5 clk = ~clk;

  letter_t exp_q[$];
  flag_t   flag_q[$];
  dir_t    dir_q[$];
  bit      mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  logic [MAXS-1:0] last_code = '0;
  logic [LW-1:0]   last_len  = '0;
  logic            last_ovf  = 1'b0;

  // Reference model: 0 waiting for a letter, 1 collecting, 2 offering.
  int m_mode = 0;
  bit m_syms[$];
  bit m_ovf = 1'b0;
  int m_gap = 0;
  int m_nlet = 0;

  function automatic logic [MAXS-1:0] model_code();
    logic [MAXS-1:0] c;
    c = '0;
    for (int i = 0; i < m_syms.size(); i++) c[i] = m_syms[i];
    return c;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_syms.delete();
    m_ovf = 1'b0;
    m_gap = 0;
  endtask

  task automatic model_step(input logic d, input logic l, input logic idle,
                            input logic tk, input logic rdy);
    bit      sym, clear, closing;
    int      mode_n;
    flag_t   f;
    letter_t e;
    sym    = d ^ l;
    mode_n = m_mode;
    f.err  = d & l;
    f.drop = sym && (m_mode == 2);
    f.rstn = !((m_mode == 2) && rdy);
    if (m_mode == 2 && rdy) begin
      e.code = model_code();
      e.len  = LW'(m_syms.size());
      e.ovf  = m_ovf;
      exp_q.push_back(e);
      m_nlet++;
      m_syms.delete();
      m_ovf  = 1'b0;
      mode_n = 0;
    end
    clear   = sym || !idle;
    closing = !clear && tk && (m_gap == GAP - 1);
    if (clear) m_gap = 0;
    else if (tk && m_gap < GAP) m_gap++;
    if (m_mode == 0 && sym) begin
      m_syms.delete();
      m_syms.push_back(l);
      m_ovf  = 1'b0;
      mode_n = 1;
    end else if (m_mode == 1) begin
      if (sym) begin
        if (m_syms.size() < MAXS) m_syms.push_back(l);
        else m_ovf = 1'b1;
      end else if (closing) begin
        mode_n = 2;
      end
    end
    m_mode  = mode_n;
    f.valid = (m_mode == 2);
    flag_q.push_back(f);
  endtask

  // One clock of stimulus: drive inputs, advance model, cross the edge.
  task automatic cyc(input logic d, input logic l, input logic idle,
                     input logic tk, input logic rdy);
    ld_dot = d;
    ld_line = l;
    key_idle = idle;
    tick = tk;
    lif.letter_ready = rdy;
    model_step(d, l, idle, tk, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic start_mon();
    mon_en = 1'b0;
    flag_q.delete();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mon_en = 1'b1;
  endtask

  task automatic idle_ticks(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, rdy);
  endtask

  task automatic check_last(input int tnum, input logic [MAXS-1:0] c,
                            input logic [LW-1:0] len, input logic ovf);
    dir_t dd;
    dd.kind = 0; dd.tnum = tnum; dd.code = c; dd.len = len; dd.ovf = ovf;
    dd.nlet = m_nlet;
    dir_q.push_back(dd);
  endtask

  task automatic check_kind(input int kind, input int tnum);
    dir_t dd;
    dd.kind = kind; dd.tnum = tnum; dd.code = '0; dd.len = '0; dd.ovf = 1'b0;
    dd.nlet = m_nlet;
    dir_q.push_back(dd);
  endtask

  // Monitor: per-cycle status, accepted letters and directed checks.
  flag_t   mf;
  letter_t me;
  dir_t    md;
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (flag_q.size() == 0) begin
        n_bad++;
        $display("FAIL status: no expectation queued at %0t", $time);
      end else begin
        mf = flag_q.pop_front();
        if ({lif.letter_valid, sym_err, sym_drop, dec_resetn} !==
            {mf.valid, mf.err, mf.drop, mf.rstn}) begin
          n_bad++;
          $display("FAIL status @%0t: got v/err/drop/rstn=%b%b%b%b want %b%b%b%b",
                   $time, lif.letter_valid, sym_err, sym_drop, dec_resetn,
                   mf.valid, mf.err, mf.drop, mf.rstn);
        end
      end
      if (lif.letter_valid && lif.letter_ready) begin
        n_cmp++;
        n_acc++;
        last_code = lif.letter_code;
        last_len  = lif.letter_len;
        last_ovf  = lif.letter_ovf;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL letter: unexpected code=%b len=%0d ovf=%0d",
                   lif.letter_code, lif.letter_len, lif.letter_ovf);
        end else begin
          me = exp_q.pop_front();
          if ({lif.letter_code, lif.letter_len, lif.letter_ovf} !==
              {me.code, me.len, me.ovf}) begin
            n_bad++;
            $display("FAIL letter #%0d: got code=%b len=%0d ovf=%0d want code=%b len=%0d ovf=%0d",
                     n_acc, lif.letter_code, lif.letter_len, lif.letter_ovf,
                     me.code, me.len, me.ovf);
          end else begin
            $display("letter #%0d code=%b len=%0d ovf=%0d", n_acc,
                     lif.letter_code, lif.letter_len, lif.letter_ovf);
          end
        end
      end
    end
    while (dir_q.size() > 0) begin
      md = dir_q.pop_front();
      n_cmp++;
      case (md.kind)
        0: if ({last_code, last_len, last_ovf} !== {md.code, md.len, md.ovf} ||
               n_acc != md.nlet) begin
             n_bad++;
             $display("FAIL test%0d letter: got code=%b len=%0d ovf=%0d count=%0d want code=%b len=%0d ovf=%0d count=%0d",
                      md.tnum, last_code, last_len, last_ovf, n_acc,
                      md.code, md.len, md.ovf, md.nlet);
           end
        1: if ({lif.letter_valid, lif.letter_code, lif.letter_len, lif.letter_ovf,
                sym_err, sym_drop, dec_resetn} !== 13'd0) begin
             n_bad++;
             $display("FAIL test%0d reset state: got v=%b code=%b len=%0d ovf=%b err=%b drop=%b rstn=%b want all 0",
                      md.tnum, lif.letter_valid, lif.letter_code, lif.letter_len,
                      lif.letter_ovf, sym_err, sym_drop, dec_resetn);
           end
        default: if (exp_q.size() != 0 || n_acc != md.nlet) begin
             n_bad++;
             $display("FAIL leftovers: got pending=%0d accepted=%0d want pending=0 accepted=%0d",
                      exp_q.size(), n_acc, md.nlet);
           end
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    lif.letter_ready = 1'b0;
    check_kind(1, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    start_mon();
    idle_ticks(8, 1'b1);

    // 1: letter A with ready held high.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_ticks(9, 1'b1);
    check_last(1, 5'b00010, 3'd2, 1'b0);

    // 2: seven dots overflow the letter.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_ticks(9, 1'b1);
    check_last(2, 5'b00000, 3'd5, 1'b1);

    // 3: T held under back-pressure, a dot arrives while offered.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_ticks(6, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(i == 4, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_ticks(3, 1'b1);
    check_last(3, 5'b00001, 3'd1, 1'b0);

    // 4: line coincides with the closing tick.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_ticks(5, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle_ticks(9, 1'b1);
    check_last(4, 5'b00010, 3'd2, 1'b0);

    // 5: dot and line together while idle.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle_ticks(10, 1'b1);
    check_last(5, 5'b00010, 3'd2, 1'b0);

    // 6: reset during collection after three symbols.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mon_en = 1'b0;
    rst = 1'b1;
    check_kind(1, 6);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    start_mon();
    idle_ticks(12, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic d, l;
      r = $urandom_range(0, 99);
      d = (r < 6) || (r >= 12 && r < 14);
      l = (r >= 6 && r < 14);
      cyc(d, l, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 60);
    end

    // Drain any open letter, then verify nothing is left pending.
    idle_ticks(20, 1'b1);
    check_kind(3, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
